// File: rtl/traffic_light_monitor.sv
// Passive checker for the red/yellow/green lamp outputs: one-hot, G->Y->R->G order,
// per-phase duration bounds, sticky first-violation code and completed-cycle counter.
module traffic_light_monitor #(
   parameter int GREEN_MIN  = 4,
   parameter int GREEN_MAX  = 6,
   parameter int YELLOW_MIN = 2,
   parameter int YELLOW_MAX = 2,
   parameter int RED_MIN    = 3,
   parameter int RED_MAX    = 5,
   parameter int CNT_W      = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             red,
   input  logic             yellow,
   input  logic             green,
   output logic [1:0]       cur_phase,
   output logic [CNT_W-1:0] phase_cnt,
   output logic [CNT_W-1:0] cycles_done,
   output logic             err,
   output logic [2:0]       err_code
);

   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [CNT_W:0]   cnt1_t;
   typedef enum logic [2:0] {S_SYNC, S_GREEN, S_YELLOW, S_RED, S_FAULT} state_t;

   localparam logic [2:0] E_NONE = 3'd0, E_ONEHOT = 3'd1, E_ORDER = 3'd2,
                          E_SHORT = 3'd3, E_LONG = 3'd4;

   // The counter must be able to hold the largest legal phase length.
   if (longint'(GREEN_MAX)  >= (longint'(1) << CNT_W) ||
       longint'(YELLOW_MAX) >= (longint'(1) << CNT_W) ||
       longint'(RED_MAX)    >= (longint'(1) << CNT_W)) begin : g_cnt_w_check
      $error("traffic_light_monitor: CNT_W too small for phase MAX values");
   end

   state_t     state, state_nx;
   cnt_t       cnt_nx, cyc_nx;
   logic [2:0] code_nx;
   logic [1:0] last_phase;
   state_t     samp_st;
   logic       one_hot;
   cnt1_t      cnt_inc;

   function automatic cnt1_t phase_min(input state_t s);
      case (s)
         S_GREEN:  return cnt1_t'(GREEN_MIN);
         S_YELLOW: return cnt1_t'(YELLOW_MIN);
         S_RED:    return cnt1_t'(RED_MIN);
         default:  return '0;
      endcase
   endfunction

   function automatic cnt1_t phase_max(input state_t s);
      case (s)
         S_GREEN:  return cnt1_t'(GREEN_MAX);
         S_YELLOW: return cnt1_t'(YELLOW_MAX);
         S_RED:    return cnt1_t'(RED_MAX);
         default:  return '0;
      endcase
   endfunction

   function automatic state_t next_in_order(input state_t s);
      case (s)
         S_GREEN:  return S_YELLOW;
         S_YELLOW: return S_RED;
         default:  return S_GREEN;
      endcase
   endfunction

   function automatic logic [1:0] phase_enc(input state_t s);
      case (s)
         S_GREEN:  return 2'd1;
         S_YELLOW: return 2'd2;
         S_RED:    return 2'd3;
         default:  return 2'd0;
      endcase
   endfunction

   assign one_hot = $onehot({red, yellow, green});
   assign samp_st = green ? S_GREEN : (yellow ? S_YELLOW : S_RED);
   assign cnt_inc = {1'b0, phase_cnt} + cnt1_t'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_SYNC;
         phase_cnt   <= '0;
         cycles_done <= '0;
         err_code    <= E_NONE;
         last_phase  <= 2'd0;
      end else begin
         state       <= state_nx;
         phase_cnt   <= cnt_nx;
         cycles_done <= cyc_nx;
         if (state != S_FAULT) begin
            err_code   <= code_nx;
            last_phase <= phase_enc(state);
         end
      end
   end

   // Violations are evaluated in priority order; the first hit wins and
   // leaves counters untouched so FAULT shows the pre-violation values.
   always_comb begin
      state_nx = state;
      cnt_nx   = phase_cnt;
      cyc_nx   = cycles_done;
      code_nx  = E_NONE;
      case (state)
         S_FAULT: ;
         S_SYNC: begin
            if (!one_hot)                         code_nx = E_ONEHOT;
            else if (cnt1_t'(1) > phase_max(samp_st)) code_nx = E_LONG;
            else begin
               state_nx = samp_st;
               cnt_nx   = cnt_t'(1);
            end
         end
         default: begin
            if (!one_hot) code_nx = E_ONEHOT;
            else if (samp_st == state) begin
               if (cnt_inc > phase_max(state)) code_nx = E_LONG;
               else                            cnt_nx  = cnt_inc[CNT_W-1:0];
            end
            else if (samp_st != next_in_order(state))      code_nx = E_ORDER;
            else if ({1'b0, phase_cnt} < phase_min(state)) code_nx = E_SHORT;
            else begin
               state_nx = samp_st;
               cnt_nx   = cnt_t'(1);
               if (state == S_RED && cycles_done != '1) cyc_nx = cycles_done + cnt_t'(1);
            end
         end
      endcase
      if (code_nx != E_NONE) state_nx = S_FAULT;
   end

   always_comb begin
      err       = (state == S_FAULT);
      cur_phase = (state == S_FAULT) ? last_phase : phase_enc(state);
   end

endmodule
